ex_muldiv_sequencer: RTL

Iterative multiply/divide sequencer that sits beside the EX pipe stage. It accepts MULT/MULTU/DIV/DIVU operands after forwarding, computes over 34 cycles, and writes the architectural HI/LO registers. It also raises a pipeline stall whenever a later instruction needs HI/LO, or the unit, while a computation is in flight.

---
 rtl/ex_muldiv_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/ex_muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit beside the EX stage: 32 shift-add or restoring-divide
// steps plus one sign-fix cycle, owning HI/LO and the pipeline stall for HI/LO or unit hazards.
module ex_muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             mf_req,
  input  logic             flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             stall
);

  // state | meaning
  // IDLE  | waiting for start; HI/LO hold last result
  // CALC  | one multiply/divide step per cycle, count 0..31
  // FIX   | sign correction, HI/LO write, done pulse
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         state;
  logic [CNT_W-1:0]   count;
  logic               is_div;
  logic               sign_a;
  logic               sign_b;
  logic               b_zero;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   mag_b;

  logic [WIDTH-1:0]   mag_a_in;
  logic [WIDTH-1:0]   mag_b_in;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  // op[0] set means unsigned: raw operands, no sign handling
  assign mag_a_in = (!op[0] && opa[WIDTH-1]) ? -opa : opa;
  assign mag_b_in = (!op[0] && opb[WIDTH-1]) ? -opb : opb;

  // Multiply: acc_hi is the upper product half, acc_lo the multiplicand shifting out
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : '0);

  // Divide: acc_hi is the remainder, acc_lo the dividend shifting into the quotient
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, mag_b};
  assign div_diff  = div_shift[WIDTH-1:0] - mag_b;

  // A zero divisor leaves rem = |opa|, so the remainder sign fix restores the original opa
  assign prod_fix = (sign_a ^ sign_b) ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
  assign quot_fix = (sign_a ^ sign_b) ? -acc_lo : acc_lo;
  assign rem_fix  = sign_a ? -acc_hi : acc_hi;

  assign busy  = (state != S_IDLE);
  assign stall = busy & (start | mf_req);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      count    <= '0;
      is_div   <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      b_zero   <= 1'b0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      mag_b    <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !flush) begin
            is_div <= op[1];
            sign_a <= !op[0] && opa[WIDTH-1];
            sign_b <= !op[0] && opb[WIDTH-1];
            b_zero <= (opb == '0);
            acc_lo <= mag_a_in;
            mag_b  <= mag_b_in;
            acc_hi <= '0;
            count  <= '0;
            state  <= S_CALC;
          end
        end
        S_CALC: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            if (is_div) begin
              acc_hi <= div_ge ? div_diff : div_shift[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
            end else begin
              acc_hi <= mul_sum[WIDTH:1];
              acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end
            count <= count + 1'b1;
            if (count == {CNT_W{1'b1}}) state <= S_FIX;
          end
        end
        S_FIX: begin
          state <= S_IDLE;
          if (!flush) begin
            done <= 1'b1;
            if (is_div) begin
              hi       <= rem_fix;
              lo       <= b_zero ? {WIDTH{1'b1}} : quot_fix;
              div_zero <= b_zero;
            end else begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
